// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 geometry, derived totals and sync
// window constants, and a helper that sizes the scan counters.
package vga_timing_pkg;

   localparam int unsigned DEF_COUNT_W  = 16;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;

   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam int unsigned DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
   localparam int unsigned DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

   // Smallest counter width able to hold 0..total-1.
   function automatic int unsigned count_width(input int unsigned total);
      if (total <= 2)
         return 1;
      return int'($clog2(total));
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one scan axis (horizontal or vertical). Wraps at TOTAL-1
// by equality compare; sync/active are registered from the next-state count
// so they line up with the count presented in the same cycle.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned COUNT_W    = DEF_COUNT_W,
   parameter int unsigned TOTAL      = DEF_H_TOTAL,
   parameter int unsigned ACTIVE     = DEF_H_ACTIVE,
   parameter int unsigned SYNC_START = DEF_H_SYNC_START,
   parameter int unsigned SYNC_END   = DEF_H_SYNC_END,
   parameter bit          POL        = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               step,
   output logic [COUNT_W-1:0] count,
   output logic               sync,
   output logic               active,
   output logic               active_nxt,
   output logic               wrap
);

   localparam logic [COUNT_W-1:0] LAST   = COUNT_W'(TOTAL - 1);
   localparam logic [COUNT_W-1:0] ACT    = COUNT_W'(ACTIVE);
   localparam logic [COUNT_W-1:0] SYNC_S = COUNT_W'(SYNC_START);
   localparam logic [COUNT_W-1:0] SYNC_E = COUNT_W'(SYNC_END);

   logic [COUNT_W-1:0] count_q, count_d;
   logic               sync_q, sync_d;
   logic               active_q, active_d;
   logic               at_last;

   assign at_last = (count_q == LAST);
   assign wrap    = step & at_last;

   // Next-state count and the sync/active flags decoded from it.
   always_comb begin
      count_d = count_q;
      if (step)
         count_d = at_last ? '0 : count_q + COUNT_W'(1);
      sync_d   = ((count_d >= SYNC_S) && (count_d <= SYNC_E)) ? POL : ~POL;
      active_d = (count_d < ACT);
   end

   // State registers; reset parks the axis at position 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q  <= '0;
         sync_q   <= ~POL;
         active_q <= 1'b1;
      end else begin
         count_q  <= count_d;
         sync_q   <= sync_d;
         active_q <= active_d;
      end
   end

   assign count      = count_q;
   assign sync       = sync_q;
   assign active     = active_q;
   assign active_nxt = active_d;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing. Horizontal axis steps on
// pix_en, vertical axis steps on the horizontal wrap.
// Optional macro VGA_FRAME_COUNT_EN adds an 8-bit wrapping frame counter
// output frame_cnt.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned COUNT_W   = DEF_COUNT_W,
   parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
   parameter int unsigned H_FP      = DEF_H_FP,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BP      = DEF_H_BP,
   parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
   parameter int unsigned V_FP      = DEF_V_FP,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BP      = DEF_V_BP,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pix_en,
   output logic [COUNT_W-1:0] h_count,
   output logic [COUNT_W-1:0] v_count,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic               line_end,
   output logic               frame_end
`ifdef VGA_FRAME_COUNT_EN
   ,
   output logic [7:0]         frame_cnt
`endif
);

   localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   logic h_wrap, v_wrap;
   logic h_act_nxt, v_act_nxt;
   logic video_on_q;

   vga_axis_counter #(
      .COUNT_W    (COUNT_W),
      .TOTAL      (H_TOTAL),
      .ACTIVE     (H_ACTIVE),
      .SYNC_START (H_SYNC_START),
      .SYNC_END   (H_SYNC_END),
      .POL        (HSYNC_POL)
   ) u_h_axis (
      .clk        (clk),
      .rst_n      (rst_n),
      .step       (pix_en),
      .count      (h_count),
      .sync       (hsync),
      .active     (),
      .active_nxt (h_act_nxt),
      .wrap       (h_wrap)
   );

   vga_axis_counter #(
      .COUNT_W    (COUNT_W),
      .TOTAL      (V_TOTAL),
      .ACTIVE     (V_ACTIVE),
      .SYNC_START (V_SYNC_START),
      .SYNC_END   (V_SYNC_END),
      .POL        (VSYNC_POL)
   ) u_v_axis (
      .clk        (clk),
      .rst_n      (rst_n),
      .step       (h_wrap),
      .count      (v_count),
      .sync       (vsync),
      .active     (),
      .active_nxt (v_act_nxt),
      .wrap       (v_wrap)
   );

   // video_on gets its own flop (from both next-state active flags) rather
   // than ANDing the two registered flags, which could glitch at line wrap.
   always_ff @(posedge clk) begin
      if (!rst_n)
         video_on_q <= 1'b1;
      else
         video_on_q <= h_act_nxt & v_act_nxt;
   end

   assign video_on  = video_on_q;
   assign line_end  = h_wrap;
   // The vertical wrap already includes the horizontal wrap via its step.
   assign frame_end = v_wrap;

`ifdef VGA_FRAME_COUNT_EN
   logic [7:0] frame_cnt_q;

   // Free-running frame counter, bumps on each frame_end tick.
   always_ff @(posedge clk) begin
      if (!rst_n)
         frame_cnt_q <= '0;
      else if (frame_end)
         frame_cnt_q <= frame_cnt_q + 8'd1;
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized scoreboard bench. The reference model tracks
// the raster as a single linear pixel index and derives every output from it.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   localparam int unsigned HA = 64, HF = 8, HS = 12, HB = 6;
   localparam int unsigned VA = 48, VF = 3, VS = 2,  VB = 4;
   localparam int unsigned HT = HA + HF + HS + HB;
   localparam int unsigned VT = VA + VF + VS + VB;
   localparam int unsigned NPIX = HT * VT;
   localparam bit HPOL = 1'b0;
   localparam bit VPOL = 1'b0;

   typedef struct packed {
      logic [15:0] h;
      logic [15:0] v;
      logic        hs;
      logic        vs;
      logic        vid;
      logic        le;
      logic        fe;
      logic [7:0]  fc;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pix_en = 1'b1;
   logic [15:0] h_count, v_count;
   logic        hsync, vsync, video_on, line_end, frame_end;
`ifdef VGA_FRAME_COUNT_EN
   logic [7:0]  frame_cnt;
`endif

   obs_t  exp_q[$];
   string tag_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned p  = 0;   // linear pixel index v*HT+h after the last edge
   int unsigned fc = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .COUNT_W   (16),
      .H_ACTIVE  (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE  (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .HSYNC_POL (HPOL),
      .VSYNC_POL (VPOL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pix_en    (pix_en),
      .h_count   (h_count),
      .v_count   (v_count),
      .hsync     (hsync),
      .vsync     (vsync),
      .video_on  (video_on),
      .line_end  (line_end),
      .frame_end (frame_end)
`ifdef VGA_FRAME_COUNT_EN
      ,
      .frame_cnt (frame_cnt)
`endif
   );

   function automatic obs_t model_obs(input int unsigned pos, input bit en,
                                      input int unsigned fcnt);
      obs_t o;
      int unsigned h, v;
      h = pos % HT;
      v = pos / HT;
      o.h   = 16'(h);
      o.v   = 16'(v);
      o.hs  = (h >= HA + HF && h < HA + HF + HS) ? HPOL : ~HPOL;
      o.vs  = (v >= VA + VF && v < VA + VF + VS) ? VPOL : ~VPOL;
      o.vid = (h < HA) && (v < VA);
      o.le  = en && (h == HT - 1);
      o.fe  = en && (pos == NPIX - 1);
`ifdef VGA_FRAME_COUNT_EN
      o.fc  = 8'(fcnt);
`else
      o.fc  = 8'(fcnt * 0);
`endif
      return o;
   endfunction

   // One clock of stimulus: drive inputs, queue the expected observation for
   // this cycle, then move the model across the coming edge.
   task automatic cycle(input bit r, input bit e, input string tag);
      @(posedge clk);
      #1;
      rst_n  = r;
      pix_en = e;
      exp_q.push_back(model_obs(p, e, fc));
      tag_q.push_back(tag);
      if (!r) begin
         p  = 0;
         fc = 0;
      end else if (e) begin
         if (p == NPIX - 1)
            fc = (fc + 1) % 256;
         p = (p + 1) % NPIX;
      end
   endtask

   // Monitor: compare DUT outputs against the queued expectation each cycle.
   always @(negedge clk) begin
      obs_t  e, a;
      string t;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a.h   = h_count;
         a.v   = v_count;
         a.hs  = hsync;
         a.vs  = vsync;
         a.vid = video_on;
         a.le  = line_end;
         a.fe  = frame_end;
`ifdef VGA_FRAME_COUNT_EN
         a.fc  = frame_cnt;
`else
         a.fc  = 8'd0;
`endif
         n_cmp++;
         if (a !== e) begin
            n_err++;
            $display("FAIL %s t=%0t got h=%0d v=%0d hs=%b vs=%b vid=%b le=%b fe=%b fc=%0d required h=%0d v=%0d hs=%b vs=%b vid=%b le=%b fe=%b fc=%0d",
                     t, $time, a.h, a.v, a.hs, a.vs, a.vid, a.le, a.fe, a.fc,
                     e.h, e.v, e.hs, e.vs, e.vid, e.le, e.fe, e.fc);
         end
      end
   end

   initial begin
      // reset held with pix_en high
      cycle(1'b0, 1'b1, "reset");
      cycle(1'b0, 1'b1, "reset");
      // 1-in-4 enable across one full line
      for (int i = 0; i < 4 * HT + 8; i++)
         cycle(1'b1, (i % 4) == 0, "gating");
      // random enable with occasional reset
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0, "random");
      // continuous enable across two full frames
      for (int i = 0; i < 2 * NPIX + 20; i++)
         cycle(1'b1, 1'b1, "frame");
      // run to (30,20) then reset for one clock
      for (int i = 0; i < NPIX && p != 20 * HT + 30; i++)
         cycle(1'b1, 1'b1, "pre_reset");
      cycle(1'b0, 1'b1, "mid_reset");
      for (int i = 0; i < 2 * HT; i++)
         cycle(1'b1, 1'b1, "post_reset");
      repeat (3) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain got %0d pending required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
